// File: rtl/instr_split_fifo.sv
// Decoding instruction FIFO: MIPS words are split into fields at push time and queued.
// Optional per-format pop counters are compiled in with INSTR_SPLIT_PERF_CNT_EN.
module instr_split_fifo #(
   parameter int DEPTH = 4,
   parameter int IMM_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instruction,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [5:0]               opcodeOut,
   output logic [4:0]               rs,
   output logic [4:0]               rt,
   output logic [4:0]               rd,
   output logic [4:0]               shamt,
   output logic [5:0]               functionCode,
   output logic [25:0]              jtarget,
   output logic [IMM_W-1:0]         imm_ext,
   output logic [1:0]               fmt,
   output logic [31:0]              r_cnt,
   output logic [31:0]              i_cnt,
   output logic [31:0]              j_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [5:0]       r_op   [DEPTH];
   logic [25:0]      r_body [DEPTH];
   logic [IMM_W-1:0] r_imm  [DEPTH];
   logic [1:0]       r_fmt  [DEPTH];

   logic             w_push;
   logic             w_pop;
   logic             w_head_valid;
   logic [5:0]       w_opcode;
   logic [1:0]       w_fmt;
   logic             w_zero_ext;
   logic [IMM_W-1:0] w_imm;

   assign w_head_valid = (r_count != '0);
   assign in_ready     = (r_count < CW'(DEPTH));
   assign out_valid    = w_head_valid;
   assign count        = r_count;
   // flush wins over any handshake on the same edge
   assign w_push       = in_valid && in_ready && !flush;
   assign w_pop        = w_head_valid && out_ready && !flush;

   assign w_opcode   = instruction[31:26];
   assign w_zero_ext = (w_opcode == 6'h0C) || (w_opcode == 6'h0D) || (w_opcode == 6'h0E);

   always_comb begin
      w_fmt = 2'b01;
      if (w_opcode == 6'h00)
         w_fmt = 2'b00;
      else if ((w_opcode == 6'h02) || (w_opcode == 6'h03))
         w_fmt = 2'b10;
   end

   generate
      if (IMM_W == 16) begin : g_imm_pass
         assign w_imm = instruction[15:0];
      end else begin : g_imm_ext
         assign w_imm = w_zero_ext ? {{(IMM_W-16){1'b0}}, instruction[15:0]}
                                   : {{(IMM_W-16){instruction[15]}}, instruction[15:0]};
      end
   endgenerate

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_op[r_wr_ptr]   <= w_opcode;
         r_body[r_wr_ptr] <= instruction[25:0];
         r_imm[r_wr_ptr]  <= w_imm;
         r_fmt[r_wr_ptr]  <= w_fmt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_comb begin
      opcodeOut    = '0;
      rs           = '0;
      rt           = '0;
      rd           = '0;
      shamt        = '0;
      functionCode = '0;
      jtarget      = '0;
      imm_ext      = '0;
      fmt          = '0;
      if (w_head_valid) begin
         opcodeOut    = r_op[r_rd_ptr];
         rs           = r_body[r_rd_ptr][25:21];
         rt           = r_body[r_rd_ptr][20:16];
         rd           = r_body[r_rd_ptr][15:11];
         shamt        = r_body[r_rd_ptr][10:6];
         functionCode = r_body[r_rd_ptr][5:0];
         jtarget      = r_body[r_rd_ptr];
         imm_ext      = r_imm[r_rd_ptr];
         fmt          = r_fmt[r_rd_ptr];
      end
   end

`ifdef INSTR_SPLIT_PERF_CNT_EN
   logic [31:0] r_rfmt_cnt;
   logic [31:0] r_ifmt_cnt;
   logic [31:0] r_jfmt_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rfmt_cnt <= '0;
         r_ifmt_cnt <= '0;
         r_jfmt_cnt <= '0;
      end else if (w_pop) begin
         case (r_fmt[r_rd_ptr])
            2'b00:   r_rfmt_cnt <= r_rfmt_cnt + 32'd1;
            2'b10:   r_jfmt_cnt <= r_jfmt_cnt + 32'd1;
            default: r_ifmt_cnt <= r_ifmt_cnt + 32'd1;
         endcase
      end
   end

   assign r_cnt = r_rfmt_cnt;
   assign i_cnt = r_ifmt_cnt;
   assign j_cnt = r_jfmt_cnt;
`else
   assign r_cnt = '0;
   assign i_cnt = '0;
   assign j_cnt = '0;
`endif
endmodule
